// File: rtl/bsg_dmc_ui_mport_arbiter.sv
// N-port round-robin front end for the DMC UI.
// Commands are arbitrated round-robin. A granted write owns the write-data
// channel until its burst completes. Read data is steered back to the issuing
// port using an in-order FIFO of port IDs.
module bsg_dmc_ui_mport_arbiter #(
    parameter int num_ports_p     = 4,
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 64,
    parameter int ui_burst_len_p  = 2,
    parameter int rd_tag_els_p    = 8,
    localparam int mask_w_lp   = ui_data_width_p / 8,
    localparam int lg_ports_lp = (num_ports_p > 1) ? $clog2(num_ports_p) : 1,
    localparam int cnt_w_lp    = $clog2(rd_tag_els_p + 1),
    localparam int lg_els_lp   = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1,
    localparam int beat_w_lp   = (ui_burst_len_p > 1) ? $clog2(ui_burst_len_p) : 1
) (
    input  logic                                    ui_clk_i,
    input  logic                                    ui_reset_n_i,
    input  logic                                    test_mode_i,
    input  logic [num_ports_p*ui_addr_width_p-1:0]  p_app_addr_i,
    input  logic [num_ports_p*3-1:0]                p_app_cmd_i,
    input  logic [num_ports_p-1:0]                  p_app_en_i,
    output logic [num_ports_p-1:0]                  p_app_rdy_o,
    input  logic [num_ports_p-1:0]                  p_app_wdf_wren_i,
    input  logic [num_ports_p*ui_data_width_p-1:0]  p_app_wdf_data_i,
    input  logic [num_ports_p*mask_w_lp-1:0]        p_app_wdf_mask_i,
    input  logic [num_ports_p-1:0]                  p_app_wdf_end_i,
    output logic [num_ports_p-1:0]                  p_app_wdf_rdy_o,
    output logic [num_ports_p-1:0]                  p_app_rd_data_valid_o,
    output logic [ui_data_width_p-1:0]              p_app_rd_data_o,
    output logic [num_ports_p-1:0]                  p_app_rd_data_end_o,
    output logic [ui_addr_width_p-1:0]              app_addr_o,
    output logic [2:0]                              app_cmd_o,
    output logic                                    app_en_o,
    input  logic                                    app_rdy_i,
    output logic                                    app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]              app_wdf_data_o,
    output logic [mask_w_lp-1:0]                    app_wdf_mask_o,
    output logic                                    app_wdf_end_o,
    input  logic                                    app_wdf_rdy_i,
    input  logic                                    app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]              app_rd_data_i,
    input  logic                                    app_rd_data_end_i,
    output logic [cnt_w_lp-1:0]                     rd_outstanding_o,
    output logic                                    error_o
);

    typedef enum logic {E_CMD, E_WDATA} state_e;

    state_e                 r_state;
    logic [lg_ports_lp-1:0] r_ptr;
    logic [lg_ports_lp-1:0] r_owner;
    logic [beat_w_lp-1:0]   r_beat;
    logic [lg_ports_lp-1:0] r_fifo [rd_tag_els_p];
    logic [lg_els_lp-1:0]   r_wr_ptr;
    logic [lg_els_lp-1:0]   r_rd_ptr;
    logic [cnt_w_lp-1:0]    r_cnt;
    logic                   r_error;

    // Per-port views of the flat port buses.
    logic [num_ports_p-1:0][ui_addr_width_p-1:0] w_addr;
    logic [num_ports_p-1:0][2:0]                 w_cmd;
    logic [num_ports_p-1:0][ui_data_width_p-1:0] w_wdata;
    logic [num_ports_p-1:0][mask_w_lp-1:0]       w_wmask;
    assign w_addr  = p_app_addr_i;
    assign w_cmd   = p_app_cmd_i;
    assign w_wdata = p_app_wdf_data_i;
    assign w_wmask = p_app_wdf_mask_i;

    logic [num_ports_p-1:0] w_elig;
    logic                   w_gnt_v;
    logic [lg_ports_lp-1:0] w_gnt, w_j, w_ptr_nxt, w_head;
    logic [2:0]             w_gcmd;
    logic w_empty, w_full, w_pop, w_blk, w_en, w_cmd_hs, w_push;
    logic w_in_wr, w_own_wren, w_beat_hs, w_last, w_wr_err, w_rd_v, w_rd_orphan;

    // Test mode leaves only the trace-replay port (port 0) eligible.
    always_comb begin
        w_elig = p_app_en_i;
        if (test_mode_i) begin
            w_elig    = '0;
            w_elig[0] = p_app_en_i[0];
        end
    end

    // Round-robin search starting at the pointer; lowest offset wins.
    always_comb begin
        w_gnt_v = 1'b0;
        w_gnt   = '0;
        w_j     = '0;
        for (int k = num_ports_p - 1; k >= 0; k--) begin
            w_j = lg_ports_lp'((int'(r_ptr) + k) % num_ports_p);
            if (w_elig[w_j]) begin
                w_gnt_v = 1'b1;
                w_gnt   = w_j;
            end
        end
    end

    assign w_gcmd    = w_cmd[w_gnt];
    assign w_ptr_nxt = (w_gnt == lg_ports_lp'(num_ports_p - 1)) ? '0 : w_gnt + lg_ports_lp'(1);
    assign w_head    = r_fifo[r_rd_ptr];

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == cnt_w_lp'(rd_tag_els_p));
    assign w_pop     = app_rd_data_valid_i & app_rd_data_end_i & ~w_empty;
    // A read cannot issue into a full tag FIFO unless a slot frees this cycle.
    assign w_blk     = (w_gcmd == 3'd1) & w_full & ~w_pop;
    assign w_en      = ui_reset_n_i & (r_state == E_CMD) & w_gnt_v & ~w_blk;
    assign w_cmd_hs  = w_en & app_rdy_i;
    assign w_push    = w_cmd_hs & (w_gcmd == 3'd1);

    assign w_in_wr    = ui_reset_n_i & (r_state == E_WDATA);
    assign w_own_wren = p_app_wdf_wren_i[r_owner];
    assign w_beat_hs  = w_in_wr & w_own_wren & app_wdf_rdy_i;
    assign w_last     = (r_beat == beat_w_lp'(ui_burst_len_p - 1));
    // wdf_end must coincide exactly with the counted last beat.
    assign w_wr_err   = w_beat_hs & (w_last ^ p_app_wdf_end_i[r_owner]);

    assign w_rd_v      = ui_reset_n_i & app_rd_data_valid_i & ~w_empty;
    assign w_rd_orphan = app_rd_data_valid_i & w_empty;

    // Command path: only the granted port sees its ready.
    always_comb begin
        p_app_rdy_o = '0;
        if (w_en) p_app_rdy_o[w_gnt] = app_rdy_i;
    end

    assign app_en_o   = w_en;
    assign app_addr_o = w_en ? w_addr[w_gnt] : '0;
    assign app_cmd_o  = w_en ? w_gcmd : 3'd0;

    // Write-data path: the burst owner is connected straight through.
    always_comb begin
        p_app_wdf_rdy_o = '0;
        if (w_in_wr) p_app_wdf_rdy_o[r_owner] = app_wdf_rdy_i;
    end

    assign app_wdf_wren_o = w_in_wr & w_own_wren;
    assign app_wdf_data_o = w_in_wr ? w_wdata[r_owner] : '0;
    assign app_wdf_mask_o = w_in_wr ? w_wmask[r_owner] : '0;
    assign app_wdf_end_o  = w_in_wr & p_app_wdf_end_i[r_owner];

    // Read return steered to the port at the FIFO head, zero latency.
    always_comb begin
        p_app_rd_data_valid_o = '0;
        p_app_rd_data_end_o   = '0;
        if (w_rd_v) begin
            p_app_rd_data_valid_o[w_head] = 1'b1;
            p_app_rd_data_end_o[w_head]   = app_rd_data_end_i;
        end
    end

    assign p_app_rd_data_o  = ui_reset_n_i ? app_rd_data_i : '0;
    assign rd_outstanding_o = ui_reset_n_i ? r_cnt : '0;
    assign error_o          = ui_reset_n_i & r_error;

    // Command/write-burst sequencing and round-robin pointer.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_reset_n_i) begin
            r_state <= E_CMD;
            r_ptr   <= '0;
            r_owner <= '0;
            r_beat  <= '0;
        end else if (r_state == E_CMD) begin
            if (w_cmd_hs) begin
                r_ptr <= w_ptr_nxt;
                if (w_gcmd == 3'd0) begin
                    r_owner <= w_gnt;
                    r_beat  <= '0;
                    r_state <= E_WDATA;
                end
            end
        end else if (w_beat_hs) begin
            if (w_last) r_state <= E_CMD;
            else        r_beat  <= r_beat + beat_w_lp'(1);
        end
    end

    // Tag FIFO pointers, occupancy and the sticky protocol error.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == lg_els_lp'(rd_tag_els_p - 1)) ? '0 : r_wr_ptr + lg_els_lp'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == lg_els_lp'(rd_tag_els_p - 1)) ? '0 : r_rd_ptr + lg_els_lp'(1);
            r_cnt <= r_cnt + cnt_w_lp'(w_push) - cnt_w_lp'(w_pop);
            if (w_wr_err | w_rd_orphan) r_error <= 1'b1;
        end
    end

    // Tag FIFO storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge ui_clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_gnt;
    end

endmodule

// File: doc/bsg_dmc_ui_mport_arbiter.md
Name: bsg_dmc_ui_mport_arbiter

Overview:
- N-port front end for bsg_dmc's Xilinx-style UI. Replaces the fixed 2:1 trace/user select with round-robin arbitration over num_ports_p requesters.
- Each granted write command owns the write-data channel until its burst completes.
- Read data is routed back to the issuing port through an in-order port-ID FIFO.
- A test-mode input restricts service to port 0, which carries the trace-replay port.

Parameters:
- num_ports_p, 4, number of UI requesters; legal range 2..16.
- ui_addr_width_p, 28, UI address width.
- ui_data_width_p, 64, UI data width; must be a multiple of 8.
- ui_burst_len_p, 2, write/read beats per command; legal range 1..16.
- rd_tag_els_p, 8, depth of the outstanding-read port-ID FIFO.

Ports:
- ui_clk_i  in  1  UI clock.
- ui_reset_n_i  in  1  synchronous reset, active low.
- test_mode_i  in  1  when 1, only port 0 is eligible for grant.
- p_app_addr_i  in  num_ports_p*ui_addr_width_p  per-port address.
- p_app_cmd_i  in  num_ports_p*3  per-port app_cmd_e.
- p_app_en_i  in  num_ports_p  per-port command valid.
- p_app_rdy_o  out  num_ports_p  per-port command accept.
- p_app_wdf_wren_i  in  num_ports_p  per-port write-data valid.
- p_app_wdf_data_i  in  num_ports_p*ui_data_width_p  per-port write data.
- p_app_wdf_mask_i  in  num_ports_p*(ui_data_width_p/8)  per-port write mask.
- p_app_wdf_end_i  in  num_ports_p  per-port last write beat.
- p_app_wdf_rdy_o  out  num_ports_p  per-port write-data accept.
- p_app_rd_data_valid_o  out  num_ports_p  per-port read-data valid.
- p_app_rd_data_o  out  ui_data_width_p  read data, broadcast to all ports.
- p_app_rd_data_end_o  out  num_ports_p  per-port last read beat.
- app_addr_o, app_cmd_o, app_en_o  out  ui_addr_width_p, 3, 1  command to DMC.
- app_rdy_i  in  1  DMC command accept.
- app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o  out  1, ui_data_width_p, ui_data_width_p/8, 1  write data to DMC.
- app_wdf_rdy_i  in  1  DMC write-data accept.
- app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i  in  1, ui_data_width_p, 1  read data from DMC.
- rd_outstanding_o  out  $clog2(rd_tag_els_p+1)  read commands awaiting data.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (ui_reset_n_i=0 at a clock edge):
  - State returns to CMD; round-robin pointer resets to port 0.
  - FIFO is emptied; beat counter and error_o go to 0.
  - Every output is 0, including all p_* ready/valid outputs and app_en_o.
  - In-flight DMC beats arriving after reset are dropped. They raise error_o only after reset has been released.
- Eligibility: port i is eligible when p_app_en_i[i]=1 and (test_mode_i=0 or i=0).
- CMD state arbitration:
  - Grant is combinational, round-robin from the pointer.
  - The granted port drives app_addr_o, app_cmd_o and app_en_o.
  - p_app_rdy_o[g] = app_rdy_i & ~blk, where blk=1 for a read command (cmd=1) when the FIFO is full and no pop occurs in the same cycle.
  - When blk=1, app_en_o is 0.
  - The grant is held (pointer frozen) until the command handshake app_en_o&app_rdy_i.
  - On the handshake, the pointer moves to g+1 mod num_ports_p.
- Write command handshake (cmd=0): latch g as the write owner, clear the beat counter, and go to WDATA.
  - No new command is granted while in WDATA. app_en_o is 0 in WDATA.
- WDATA state:
  - The owner's wdf inputs pass to app_wdf_*_o.
  - p_app_wdf_rdy_o[owner] = app_wdf_rdy_i. All other ports' wdf_rdy are 0.
  - Each beat handshake (wren&rdy) increments the counter.
  - The beat with counter==ui_burst_len_p-1 returns to CMD next cycle.
  - Its wdf_end must be 1. If not, or if wdf_end=1 arrives earlier, set error_o and still complete on the counter.
- Write data presented outside WDATA is not accepted (wdf_rdy=0). Write data never precedes its command.
- Read command handshake: push g into the FIFO in the same cycle.
- Read return:
  - Each app_rd_data_valid_i beat goes to port FIFO head: p_app_rd_data_valid_o[head]=1, and p_app_rd_data_end_o[head]=app_rd_data_end_i.
  - Pop on valid&end.
  - Return is combinational, zero latency. Ports have no backpressure on read data.
- Read data valid with the FIFO empty: set error_o, drop the beat.
- Full FIFO with a push and pop in the same cycle: both occur and the count is unchanged.
- rd_outstanding_o equals the FIFO count.
- test_mode_i change:
  - Takes effect at the next CMD-state grant.
  - It never aborts a WDATA burst.
  - Reads outstanding to other ports still return to those ports.
- Simultaneous write-command handshake and read-data beat: both are processed independently.

Test Plan:
- 4 ports, all issue reads to addresses 0x10/0x20/0x30/0x40 back-to-back with app_rdy_i=1.
  - Grants go 0,1,2,3.
  - DMC returns 4 bursts of 2 beats; beats appear on ports 0,1,2,3 in order.
  - rd_outstanding_o goes 1,2,3,4 then back to 0.
- Port 2 writes with burst_len 2 while port 1 holds app_en_i.
  - Port 1 is not granted until port 2's second beat is accepted with app_wdf_rdy_i toggling 1,0,1.
  - app_wdf_data_o equals port 2's data on both beats.
- rd_tag_els_p=8; issue 9 reads with the DMC returning no data.
  - The 9th read sees p_app_rdy_o=0 and app_en_o=0.
  - After one rd_data_end the 9th read is accepted the same cycle the pop occurs.
- test_mode_i=1 with ports 0 and 3 requesting: only port 0 is granted.
  - Drop test_mode_i during port 0's write burst: the burst completes, then port 3 is granted.
- Protocol errors:
  - wdf_end=1 on beat 0 of a 2-beat burst → error_o=1 sticky, burst still completes after 2 beats.
  - Read data valid with the FIFO empty → error_o=1.
- Reset asserted mid-WDATA with 3 reads outstanding.
  - Next cycle: all outputs 0, rd_outstanding_o=0, pointer at port 0.
  - Port 1's request is then granted first.
